// File: rtl/mmio_if.sv
// Core-side M-stage access bus plus the UART TX/RX handshakes for mmio_ctrl.
interface mmio_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] mem_adrM;
    logic [XLEN-1:0] mem_wdataM;
    logic [3:0]      wea;
    logic            mem_reM;
    logic            instr_valid;
    logic [XLEN-1:0] io_rdata;
    logic            io_hit;
    logic [7:0]      uart_tx_data;
    logic            uart_tx_valid;
    logic            uart_tx_ready;
    logic [7:0]      uart_rx_data;
    logic            uart_rx_valid;
    logic            uart_rx_ready;

    // Core + UART side: drives accesses and handshakes, observes read data.
    modport master (
        output mem_adrM, mem_wdataM, wea, mem_reM, instr_valid,
        output uart_tx_ready, uart_rx_data, uart_rx_valid,
        input  io_rdata, io_hit, uart_tx_data, uart_tx_valid, uart_rx_ready
    );

    // Controller side.
    modport slave (
        input  mem_adrM, mem_wdataM, wea, mem_reM, instr_valid,
        input  uart_tx_ready, uart_rx_data, uart_rx_valid,
        output io_rdata, io_hit, uart_tx_data, uart_tx_valid, uart_rx_ready
    );
endinterface

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: UART TX FIFO, UART RX holding register,
// cycle / retired-instruction counters, and a 1-cycle registered read path
// aligned with the data-memory writeback.
module mmio_ctrl #(
    parameter int         XLEN        = 32,
    parameter int         TX_DEPTH    = 4,
    parameter logic [3:0] IO_BASE_NIB = 4'h8
) (
    input logic   clk,
    input logic   rst,
    mmio_if.slave bus
);
    localparam int PW = $clog2(TX_DEPTH);

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_INSTR  = 8'h14;
    localparam logic [7:0] OFF_CNTRST = 8'h18;

    logic [7:0]      txMem [TX_DEPTH];
    logic [PW:0]     txWrPtr, txRdPtr;
    logic            txFull, txEmpty, txOverflow;
    logic            txPush, txDrop, txPop;
    logic            rxFull, rxCap, rxPop;
    logic [7:0]      rxByte;
    logic [31:0]     cycleCnt, instrCnt;
    logic            ioSel, ioLoad, ioStore, cntClr;
    logic [7:0]      offset;
    logic [XLEN-1:0] rdNext;
    logic            unusedBits;

    // Only the top nibble selects I/O space and the low byte picks the register.
    assign unusedBits = ^{bus.mem_adrM[27:8], bus.mem_wdataM[XLEN-1:8]};

    assign ioSel   = (bus.mem_adrM[31:28] == IO_BASE_NIB);
    assign offset  = bus.mem_adrM[7:0];
    assign ioLoad  = bus.mem_reM && ioSel;
    assign ioStore = (|bus.wea) && ioSel;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign txEmpty = (txWrPtr == txRdPtr);
    assign txFull  = (txWrPtr[PW] != txRdPtr[PW]) &&
                     (txWrPtr[PW-1:0] == txRdPtr[PW-1:0]);
    assign txPop   = !txEmpty && bus.uart_tx_ready;
    // Full is judged on pre-edge state: a same-cycle pop does not make room.
    assign txPush  = ioStore && (offset == OFF_TXDATA) && !txFull;
    assign txDrop  = ioStore && (offset == OFF_TXDATA) && txFull;

    assign rxCap   = bus.uart_rx_valid && !rxFull;
    assign rxPop   = ioLoad && (offset == OFF_RXDATA) && rxFull;
    assign cntClr  = ioStore && (offset == OFF_CNTRST);

    assign bus.uart_tx_valid = !txEmpty;
    assign bus.uart_tx_data  = txEmpty ? 8'h00 : txMem[txRdPtr[PW-1:0]];
    assign bus.uart_rx_ready = !rxFull;

    // FIFO storage; contents are don't-care once the pointers say empty.
    always_ff @(posedge clk) begin
        if (txPush) txMem[txWrPtr[PW-1:0]] <= bus.mem_wdataM[7:0];
    end

    // FIFO pointers and the sticky overflow flag (cleared by any CTRL store).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txWrPtr    <= '0;
            txRdPtr    <= '0;
            txOverflow <= 1'b0;
        end else begin
            if (txPush) txWrPtr <= txWrPtr + 1'b1;
            if (txPop)  txRdPtr <= txRdPtr + 1'b1;
            if (txDrop)
                txOverflow <= 1'b1;
            else if (ioStore && (offset == OFF_CTRL))
                txOverflow <= 1'b0;
        end
    end

    // RX holding register: capture only while empty, a load of RX_DATA empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxFull <= 1'b0;
            rxByte <= 8'h00;
        end else if (rxCap) begin
            rxFull <= 1'b1;
            rxByte <= bus.uart_rx_data;
        end else if (rxPop) begin
            rxFull <= 1'b0;
        end
    end

    // Free-running counters; a CNT_RST store beats that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycleCnt <= '0;
            instrCnt <= '0;
        end else if (cntClr) begin
            cycleCnt <= '0;
            instrCnt <= '0;
        end else begin
            cycleCnt <= cycleCnt + 32'd1;
            if (bus.instr_valid) instrCnt <= instrCnt + 32'd1;
        end
    end

    // Read mux over pre-edge state; unmapped offsets read as zero.
    always_comb begin
        rdNext = '0;
        case (offset)
            OFF_CTRL:   rdNext = XLEN'({txOverflow, rxFull, !txFull});
            OFF_RXDATA: rdNext = XLEN'(rxByte);
            OFF_CYCLE:  rdNext = XLEN'(cycleCnt);
            OFF_INSTR:  rdNext = XLEN'(instrCnt);
            default:    rdNext = '0;
        endcase
    end

    // Writeback-stage read register and mux select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.io_rdata <= '0;
            bus.io_hit   <= 1'b0;
        end else begin
            bus.io_rdata <= ioLoad ? rdNext : '0;
            bus.io_hit   <= ioLoad;
        end
    end
endmodule

// File: doc/mmio_ctrl.md
Name: mmio_ctrl

Overview:
- Memory-mapped I/O controller sitting directly downstream of the core's memory stage.
- Consumes the M-stage data address, write data and byte write enables. Returns registered read data in the writeback cycle, aligned with the data-memory read path.
- Owns the UART TX FIFO, the UART RX holding register, and the cycle and retired-instruction counters.

Parameters:
- XLEN, 32, data/address width.
- TX_DEPTH, 4, TX FIFO entries; power of two, at least 2.
- IO_BASE_NIB, 4'h8, value of addr[31:28] that selects I/O space.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- mem_adrM  in  XLEN  M-stage data address
- mem_wdataM  in  XLEN  M-stage store data
- wea  in  4  M-stage byte write enables; any nonzero value is a store
- mem_reM  in  1  M-stage load is in progress
- instr_valid  in  1  one instruction retired this cycle
- io_rdata  out  XLEN  registered read data, valid the cycle after the load
- io_hit  out  1  registered; the previous cycle's load addressed I/O space (writeback mux select)
- uart_tx_data  out  8  TX FIFO head
- uart_tx_valid  out  1  TX FIFO non-empty
- uart_tx_ready  in  1  transmitter accepts the head
- uart_rx_data  in  8  received byte
- uart_rx_valid  in  1  received byte available
- uart_rx_ready  out  1  RX holding register empty

Behaviour:
- Decode: io_sel = (mem_adrM[31:28] == IO_BASE_NIB). Only mem_adrM[7:0] is decoded. Non-I/O accesses have no side effects.
- Address map (offsets):
  - 0x00 CTRL. Read: {29'b0, tx_overflow, rx_full, !tx_full}. Any store clears tx_overflow.
  - 0x04 RX_DATA. Read returns {24'b0, rx_byte}. A load pops the register: rx_full is 0 next cycle. A load while empty returns the stale byte and has no effect.
  - 0x08 TX_DATA. A store pushes mem_wdataM[7:0].
  - 0x10 CYCLE_CNT (read only).
  - 0x14 INSTR_CNT (read only).
  - 0x18 CNT_RST. Any store clears both counters.
  - Unmapped offsets: reads return 0, stores are ignored.
- Read path:
  - io_rdata and io_hit are registered at the clk edge after mem_reM && io_sel.
  - Latency is exactly 1 cycle.
  - When the load is not to I/O, io_hit = 0 and io_rdata = 0.
  - Reads return pre-edge values (e.g. a counter read returns the value before that cycle's increment).
- TX FIFO:
  - Circular buffer with log2(TX_DEPTH)+1-bit pointers; full and empty are derived from the pointer MSB compare.
  - Pop occurs when uart_tx_valid && uart_tx_ready.
  - Push occurs on a store to 0x08 when !tx_full, evaluated on pre-edge state. A push while full is dropped and sets sticky tx_overflow, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: occupancy is unchanged.
  - A byte pushed into an empty FIFO appears on uart_tx_data with uart_tx_valid = 1 the next cycle.
  - Pointer wrap-around is seamless across TX_DEPTH.
- RX holding register:
  - uart_rx_ready = !rx_full.
  - Capture occurs when uart_rx_valid && uart_rx_ready: rx_byte is loaded and rx_full = 1.
  - A capture and a pop cannot occur in the same cycle because ready is low when full.
- Counters:
  - Both counters are 32-bit and wrap 0xFFFFFFFF -> 0.
  - cycle_cnt increments every cycle.
  - instr_cnt increments when instr_valid = 1.
  - A CNT_RST store sets both counters to 0 at the next edge; the clear overrides that cycle's increment.
- Reset (asynchronous, mid-operation included) clears:
  - the TX FIFO to empty (contents discarded);
  - rx_full, rx_byte, tx_overflow;
  - both counters;
  - io_rdata, io_hit.
- Output values in reset: uart_tx_valid = 0, uart_tx_data = 0, uart_rx_ready = 1, io_rdata = 0, io_hit = 0.
- Store and load in the same cycle (both wea and mem_reM set) is illegal from the core; on that input, the store takes effect and the read returns pre-edge state.

Test Plan:
- Reset, then idle 10 cycles with instr_valid high on 6 of them -> load 0x80000010 returns 10, load 0x80000014 returns 6, io_hit = 1 one cycle after each load.
- Store 0x41, 0x42, 0x43, 0x44, 0x45 to 0x80000008 with uart_tx_ready = 0 -> FIFO full after 4 stores; CTRL reads 0x4 (overflow set, tx not ready); release uart_tx_ready -> bytes 0x41..0x44 emitted in order, then uart_tx_valid = 0 and CTRL reads 0x5.
- Drive uart_rx_valid with 0x5A -> uart_rx_ready drops next cycle and CTRL bit1 = 1; load 0x80000004 returns 0x5A, then uart_rx_ready = 1; a second load returns 0x5A with no state change.
- Fill TX to 3 entries, then push while popping on the same edge -> occupancy stays 3 and order is preserved across pointer wrap.
- Preload cycle_cnt near 0xFFFFFFFE (force), run 3 cycles -> wraps to 0x1; store to 0x80000018 while instr_valid = 1 -> both counters read 0/1 correctly (clear wins, then counting resumes).
- Assert rst mid-transmission with 2 bytes queued and rx_full = 1 -> uart_tx_valid = 0, uart_rx_ready = 1 and counters = 0 immediately; load 0x00001000 -> io_hit = 0, io_rdata = 0.
